// File: rtl/writeback_stage.sv
// -----------------------------------------------------------------------------
// writeback_stage
//
// Merges load (mem) and ALU results into a single register-bank write port.
// Per cycle at most one result commits. The priority is an accepted load
// first, then a parked ALU result, then a freshly accepted ALU result. An ALU
// result that loses to a load is parked in a one-entry skid buffer. A result
// aimed at the PC (index AmountOfRegisters-1) is consumed, is not written, and
// raises pcWriteError for one cycle. A scoreboard tracks registers that decode
// has reserved but that have not yet been written back.
//
// Ports
//   clk           : clock, all state updates on its rising edge
//   reset         : asynchronous, active-low reset
//   issueValid    : decode reserves issueRegister this cycle
//   issueRegister : register being reserved
//   aluValid      : ALU result offered
//   aluRegister   : ALU result destination
//   aluValue      : ALU result data
//   aluReady      : ALU result can be accepted (skid buffer empty)
//   memValid      : load result offered
//   memRegister   : load result destination
//   memValue      : load result data
//   memReady      : load result can be accepted (always, outside reset)
//   writeEnable   : registered write strobe to the register bank
//   writeRegister : registered write index
//   writeValue    : registered write data
//   busy          : scoreboard, bit r set while register r is outstanding
//   pcWriteError  : one-cycle pulse when a PC-targeted result is dropped
// -----------------------------------------------------------------------------
module writeback_stage #(
    parameter int RegisterSize      = 32,
    parameter int AmountOfRegisters = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         issueValid,
    input  logic [3:0]                   issueRegister,
    input  logic                         aluValid,
    input  logic [3:0]                   aluRegister,
    input  logic [RegisterSize-1:0]      aluValue,
    output logic                         aluReady,
    input  logic                         memValid,
    input  logic [3:0]                   memRegister,
    input  logic [RegisterSize-1:0]      memValue,
    output logic                         memReady,
    output logic                         writeEnable,
    output logic [3:0]                   writeRegister,
    output logic [RegisterSize-1:0]      writeValue,
    output logic [AmountOfRegisters-1:0] busy,
    output logic                         pcWriteError
);

    localparam logic [3:0] PcIndex = 4'(AmountOfRegisters - 1);
    localparam logic [AmountOfRegisters-1:0] OneBit = {{(AmountOfRegisters-1){1'b0}}, 1'b1};

    logic                    skid_full;
    logic [3:0]              skid_register;
    logic [RegisterSize-1:0] skid_value;

    logic                    mem_accept;
    logic                    alu_accept;
    logic                    commit_valid;
    logic [3:0]              commit_register;
    logic [RegisterSize-1:0] commit_value;
    logic                    commit_to_pc;
    logic                    skid_load;
    logic                    skid_drain;
    logic [AmountOfRegisters-1:0] set_mask;
    logic [AmountOfRegisters-1:0] clear_mask;

    // Both ready signals are forced low while reset is held.
    assign memReady   = reset;
    assign aluReady   = reset & ~skid_full;
    assign mem_accept = memValid & memReady;
    assign alu_accept = aluValid & aluReady;

    // Commit selection. alu_accept implies the skid is empty, so the only case
    // that parks an ALU result is a simultaneous load acceptance.
    always_comb begin
        commit_valid    = 1'b0;
        commit_register = '0;
        commit_value    = '0;
        skid_load       = 1'b0;
        skid_drain      = 1'b0;
        if (mem_accept) begin
            commit_valid    = 1'b1;
            commit_register = memRegister;
            commit_value    = memValue;
            skid_load       = alu_accept;
        end else if (skid_full) begin
            commit_valid    = 1'b1;
            commit_register = skid_register;
            commit_value    = skid_value;
            skid_drain      = 1'b1;
        end else if (alu_accept) begin
            commit_valid    = 1'b1;
            commit_register = aluRegister;
            commit_value    = aluValue;
        end
    end

    assign commit_to_pc = commit_valid && (commit_register == PcIndex);

    // A guarded PC commit still retires its scoreboard bit; a same-edge
    // reservation of that bit overrides the clear.
    assign set_mask   = issueValid   ? (OneBit << issueRegister)   : '0;
    assign clear_mask = commit_valid ? (OneBit << commit_register) : '0;

    // ---- control state and registered write port ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            skid_full     <= 1'b0;
            writeEnable   <= 1'b0;
            writeRegister <= '0;
            writeValue    <= '0;
            busy          <= '0;
            pcWriteError  <= 1'b0;
        end else begin
            if (skid_load) begin
                skid_full <= 1'b1;
            end else if (skid_drain) begin
                skid_full <= 1'b0;
            end
            writeEnable  <= commit_valid & ~commit_to_pc;
            pcWriteError <= commit_to_pc;
            // Index and data hold on idle cycles and on dropped PC writes.
            if (commit_valid && !commit_to_pc) begin
                writeRegister <= commit_register;
                writeValue    <= commit_value;
            end
            busy <= (busy & ~clear_mask) | set_mask;
        end
    end

    // Skid payload is qualified by skid_full, so it needs no reset.
    always_ff @(posedge clk) begin
        if (skid_load) begin
            skid_register <= aluRegister;
            skid_value    <= aluValue;
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// -----------------------------------------------------------------------------
// tb_writeback_stage
//
// Directed test of writeback_stage: reset values, uncontested load, load/ALU
// contention through the skid buffer, back-to-back loads, scoreboard set/clear
// interaction, PC write guard, and reset while the skid and scoreboard are full.
// -----------------------------------------------------------------------------
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        issueValid;
    logic [3:0]  issueRegister;
    logic        aluValid;
    logic [3:0]  aluRegister;
    logic [31:0] aluValue;
    logic        aluReady;
    logic        memValid;
    logic [3:0]  memRegister;
    logic [31:0] memValue;
    logic        memReady;
    logic        writeEnable;
    logic [3:0]  writeRegister;
    logic [31:0] writeValue;
    logic [15:0] busy;
    logic        pcWriteError;

    int n_compared   = 0;
    int n_mismatched = 0;

    writeback_stage #(
        .RegisterSize      (32),
        .AmountOfRegisters (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .issueValid    (issueValid),
        .issueRegister (issueRegister),
        .aluValid      (aluValid),
        .aluRegister   (aluRegister),
        .aluValue      (aluValue),
        .aluReady      (aluReady),
        .memValid      (memValid),
        .memRegister   (memRegister),
        .memValue      (memValue),
        .memReady      (memReady),
        .writeEnable   (writeEnable),
        .writeRegister (writeRegister),
        .writeValue    (writeValue),
        .busy          (busy),
        .pcWriteError  (pcWriteError)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic idle();
        issueValid    = 1'b0;
        issueRegister = 4'd0;
        aluValid      = 1'b0;
        aluRegister   = 4'd0;
        aluValue      = 32'd0;
        memValid      = 1'b0;
        memRegister   = 4'd0;
        memValue      = 32'd0;
    endtask

    // Advance one rising edge; inputs change and outputs are sampled 1 time
    // unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_mem(input logic [3:0] r, input logic [31:0] v);
        memValid = 1'b1; memRegister = r; memValue = v;
    endtask

    task automatic drive_alu(input logic [3:0] r, input logic [31:0] v);
        aluValid = 1'b1; aluRegister = r; aluValue = v;
    endtask

    task automatic drive_issue(input logic [3:0] r);
        issueValid = 1'b1; issueRegister = r;
    endtask

    task automatic check_write(input string tag, input logic [3:0] r, input logic [31:0] v);
        check({tag, "_we"}, 64'(writeEnable), 64'd1);
        check({tag, "_reg"}, 64'(writeRegister), 64'(r));
        check({tag, "_val"}, 64'(writeValue), 64'(v));
    endtask

    initial begin
        idle();
        #1 reset = 1'b0;
        #1;
        // Reset state
        check("rst_we", 64'(writeEnable), 64'd0);
        check("rst_reg", 64'(writeRegister), 64'd0);
        check("rst_val", 64'(writeValue), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(pcWriteError), 64'd0);
        check("rst_aluReady", 64'(aluReady), 64'd0);
        check("rst_memReady", 64'(memReady), 64'd0);
        step(); step();
        reset = 1'b1;
        #1;
        check("rel_aluReady", 64'(aluReady), 64'd1);
        check("rel_memReady", 64'(memReady), 64'd1);

        // Uncontested load
        drive_mem(4'd3, 32'hA5A5A5A5);
        step(); idle();
        check_write("mem1", 4'd3, 32'hA5A5A5A5);
        step();
        check("mem1_idle_we", 64'(writeEnable), 64'd0);
        check("mem1_hold_reg", 64'(writeRegister), 64'd3);
        check("mem1_hold_val", 64'(writeValue), 64'hA5A5A5A5);

        // Load and ALU contend: load first, ALU one cycle later
        drive_mem(4'd1, 32'h11);
        drive_alu(4'd2, 32'h22);
        step(); idle();
        check_write("cont_mem", 4'd1, 32'h11);
        check("cont_aluReady0", 64'(aluReady), 64'd0);
        step();
        check_write("cont_alu", 4'd2, 32'h22);
        check("cont_aluReady1", 64'(aluReady), 64'd1);
        step();
        check("cont_idle_we", 64'(writeEnable), 64'd0);

        // Three back-to-back loads while the ALU keeps offering
        drive_mem(4'd4, 32'h100);
        drive_alu(4'd6, 32'h600);
        step();
        drive_mem(4'd7, 32'h200);
        drive_alu(4'd8, 32'h800);
        check_write("b2b_m1", 4'd4, 32'h100);
        check("b2b_rdy1", 64'(aluReady), 64'd0);
        step();
        drive_mem(4'd9, 32'h300);
        check_write("b2b_m2", 4'd7, 32'h200);
        check("b2b_rdy2", 64'(aluReady), 64'd0);
        step();
        memValid = 1'b0;
        check_write("b2b_m3", 4'd9, 32'h300);
        check("b2b_rdy3", 64'(aluReady), 64'd0);
        step();
        check_write("b2b_skid", 4'd6, 32'h600);
        check("b2b_rdy4", 64'(aluReady), 64'd1);
        step(); idle();
        check_write("b2b_alu2", 4'd8, 32'h800);
        step();
        check("b2b_idle_we", 64'(writeEnable), 64'd0);

        // Scoreboard
        drive_issue(4'd5);
        step(); idle();
        check("sb_set5", 64'(busy), 64'h0020);
        drive_issue(4'd5);
        drive_alu(4'd5, 32'h55);
        step(); idle();
        check("sb_setwins", 64'(busy), 64'h0020);
        check_write("sb_w5a", 4'd5, 32'h55);
        drive_alu(4'd5, 32'h56);
        step(); idle();
        check("sb_clear5", 64'(busy), 64'h0000);
        drive_issue(4'd1);
        step(); idle();
        check("sb_set1", 64'(busy), 64'h0002);
        drive_issue(4'd2);
        drive_alu(4'd1, 32'h61);
        step(); idle();
        check("sb_both", 64'(busy), 64'h0004);
        drive_alu(4'd2, 32'h62);
        step(); idle();
        check("sb_clear2", 64'(busy), 64'h0000);
        check_write("sb_w2", 4'd2, 32'h62);

        // PC guard
        drive_issue(4'd15);
        step(); idle();
        check("pc_busy_set", 64'(busy), 64'h8000);
        drive_alu(4'd15, 32'hDEAD);
        step(); idle();
        check("pc_we", 64'(writeEnable), 64'd0);
        check("pc_err", 64'(pcWriteError), 64'd1);
        check("pc_busy_clr", 64'(busy), 64'h0000);
        check("pc_hold_reg", 64'(writeRegister), 64'd2);
        check("pc_hold_val", 64'(writeValue), 64'h62);
        step();
        check("pc_err_pulse", 64'(pcWriteError), 64'd0);

        // Reset with skid full and every scoreboard bit set
        drive_mem(4'd3, 32'h33);
        drive_alu(4'd4, 32'h44);
        step(); idle();
        for (int i = 0; i < 16; i++) begin
            drive_issue(4'(i));
            drive_mem(4'(i), 32'h1000 + 32'(i));
            step();
        end
        idle();
        check("full_busy", 64'(busy), 64'hFFFF);
        check("full_aluReady", 64'(aluReady), 64'd0);
        check("full_err", 64'(pcWriteError), 64'd1);
        reset = 1'b0;
        #1;
        check("mid_we", 64'(writeEnable), 64'd0);
        check("mid_reg", 64'(writeRegister), 64'd0);
        check("mid_val", 64'(writeValue), 64'd0);
        check("mid_busy", 64'(busy), 64'd0);
        check("mid_err", 64'(pcWriteError), 64'd0);
        check("mid_aluReady", 64'(aluReady), 64'd0);
        check("mid_memReady", 64'(memReady), 64'd0);
        step(); step();
        reset = 1'b1;
        #1;
        check("post_aluReady", 64'(aluReady), 64'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            check("post_no_stale_we", 64'(writeEnable), 64'd0);
        end
        drive_mem(4'd2, 32'h77);
        step(); idle();
        check_write("post_first", 4'd2, 32'h77);
        step();
        check("post_idle_we", 64'(writeEnable), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
